// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types, LFSR taps and limit-mask helper for rand_arbiter
package rand_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROLL,
        ST_DONE
    } state_t;

    localparam logic [7:0] DEFAULT_SEED = 8'h0F;

    localparam int TAP_A = 7;
    localparam int TAP_B = 3;
    localparam int TAP_C = 2;
    localparam int TAP_D = 0;

    // Smallest 2^k-1 covering lim: smear the top set bit downward.
    function automatic logic [7:0] mask_of(input logic [7:0] lim);
        logic [7:0] m;
        m = lim;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - 8-bit Fibonacci LFSR, advances only when step is high
module lfsr_core
    import rand_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] state
);

    logic feedback;

    assign feedback = state[TAP_A] ^ state[TAP_B] ^ state[TAP_C] ^ state[TAP_D];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEED;
        end else if (step) begin
            state <= {state[6:0], feedback};
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// rtl/rand_arbiter.sv - round-robin access to one LFSR with bounded rejection sampling
// RAND_FREERUN_EN: LFSR steps every cycle instead of only while rolling.
module rand_arbiter
    import rand_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         WIDTH     = 8,
    parameter logic [7:0] SEED      = DEFAULT_SEED,
    parameter int         MAX_TRIES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] limit,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rvalid,
    output logic [2:0]               rid,
    output logic [WIDTH-1:0]         rdata
);

    localparam logic [3:0]         TRY_CAP = 4'(MAX_TRIES);
    localparam logic [2:0]         LAST_ID = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT = 1;

    state_t           state;
    logic [2:0]       ptr;
    logic [2:0]       sel;
    logic [3:0]       try_cnt;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] cand;
    logic             lfsr_step;
    logic [2:0]       pick;
    logic             found;

`ifdef RAND_FREERUN_EN
    assign lfsr_step = 1'b1;
`else
    assign lfsr_step = (state == ST_ROLL);
`endif

    lfsr_core #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .step  (lfsr_step),
        .state (lfsr)
    );

    assign cand = lfsr & mask_of(lim_q);

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            ptr     <= '0;
            sel     <= '0;
            try_cnt <= '0;
            lim_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        sel     <= pick;
                        lim_q   <= limit[int'(pick)*WIDTH +: WIDTH];
                        gnt     <= ONE_HOT << pick;
                        try_cnt <= 4'd1;
                        state   <= ST_ROLL;
                    end
                end
                ST_ROLL: begin
                    if (cand <= lim_q) begin
                        rdata  <= cand;
                        rid    <= sel;
                        rvalid <= 1'b1;
                        state  <= ST_DONE;
                    end else if (try_cnt == TRY_CAP) begin
                        // cand <= 2*lim+1 here, so the shifted value stays in range.
                        rdata  <= cand - (lim_q + 1'b1);
                        rid    <= sel;
                        rvalid <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        try_cnt <= try_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    rvalid <= 1'b0;
                    gnt    <= '0;
                    ptr    <= (sel == LAST_ID) ? 3'd0 : sel + 3'd1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_arbiter.sv
// tb/tb_rand_arbiter.sv - directed scoreboard bench for rand_arbiter (default build)
module tb_rand_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] limit;
    logic [3:0]  gnt;
    logic        rvalid;
    logic [2:0]  rid;
    logic [7:0]  rdata;

    int total;
    int passed;

    typedef struct {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    rand_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .SEED      (8'h0F),
        .MAX_TRIES (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .limit  (limit),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rid    (rid),
        .rdata  (rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every rvalid pops one expected result.
    always @(negedge clock) begin
        if (rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rid", 32'(rid), 32'(e.id));
                check("rdata", 32'(rdata), 32'(e.data));
                check("gnt_in_done", 32'(gnt), 32'(4'b0001 << e.id));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One single-requester service with exact latency checks (t = ROLL cycles).
    task automatic serve(input logic [3:0] r, input logic [2:0] id, input logic [7:0] d,
                         input int t, input logic [7:0] lim_after);
        exp_t e;
        e.id = id;
        e.data = d;
        sb.push_back(e);
        @(negedge clock);
        req = r;
        @(posedge clock);
        #1;
        check("gnt_n_plus_1", 32'(gnt), 32'(r));
        check("no_early_rvalid", 32'(rvalid), 32'd0);
        req = '0;
        limit[7:0] = lim_after;
        repeat (t) @(posedge clock);
        #1;
        check("rvalid_latency", 32'(rvalid), 32'd1);
        @(posedge clock);
        #1;
        check("rvalid_pulse_end", 32'(rvalid), 32'd0);
        check("gnt_released", 32'(gnt), 32'd0);
    endtask

    initial begin
        exp_t e;
        logic [7:0] seq[5];
        int budget;
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        req    = '0;
        limit  = '0;

        do_reset();
        #1;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rid", 32'(rid), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);

        limit[7:0] = 8'd255;
        serve(4'b0001, 3'd0, 8'h0F, 1, 8'd255);
        serve(4'b0001, 3'd0, 8'h1F, 1, 8'd255);
        check("rdata_hold", 32'(rdata), 32'h1F);

        limit[7:0] = 8'd0;
        serve(4'b0001, 3'd0, 8'h00, 1, 8'd0);

        // Fallback path; limit changed after grant must be ignored.
        do_reset();
        limit[7:0] = 8'd10;
        serve(4'b0001, 3'd0, 8'h04, 4, 8'd255);

        // Round robin with all requesters held.
        do_reset();
        limit = 32'hFFFF_FFFF;
        seq[0] = 8'h0F; seq[1] = 8'h1F; seq[2] = 8'h3F; seq[3] = 8'h7F; seq[4] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            e.id = 3'(i % 4);
            e.data = seq[i];
            sb.push_back(e);
        end
        @(negedge clock);
        req = 4'b1111;
        budget = 0;
        while (sb.size() != 0 && budget < 40) begin
            @(negedge clock);
            budget++;
        end
        req = '0;
        check("rr_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (4) @(posedge clock);

        // Reset during ROLL loses the service.
        do_reset();
        limit[7:0] = 8'd10;
        @(negedge clock);
        req = 4'b0001;
        @(posedge clock);
        #1;
        check("abort_gnt", 32'(gnt), 32'd1);
        req = '0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_gnt_cleared", 32'(gnt), 32'd0);
        check("abort_no_rvalid", 32'(rvalid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("abort_still_quiet", 32'(rvalid), 32'd0);
        limit[7:0] = 8'd255;
        serve(4'b0001, 3'd0, 8'h0F, 1, 8'd255);

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
